// File: rtl/bin2qdi_1ofn_src_if.sv
// bin2qdi_1ofn_src_if: word stream in, 1-of-N rails out, Re enable back from the circuit
interface bin2qdi_1ofn_src_if #(
  parameter int W = 8,
  parameter int N = 16
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [N-1:0] R;
  logic         Re;
  modport master (output din, din_valid, Re, input din_ready, R);
  modport slave  (input din, din_valid, Re, output din_ready, R);
endinterface

// File: rtl/bin2qdi_1ofn_src.sv
// bin2qdi_1ofn_src: FIFO-buffered binary words driven out as multi-digit 1-of-RADIX four-phase tokens
module bin2qdi_1ofn_src #(
  parameter int RADIX       = 4,
  parameter int DIGITS      = 4,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  bin2qdi_1ofn_src_if.slave bus,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_proto,
  output logic [15:0]       tok_count,
  inout  wire               VDD,
  inout  wire               GND
);
  localparam int B   = $clog2(RADIX);
  localparam int W   = DIGITS * B;
  localparam int N   = DIGITS * RADIX;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, NEUTRAL} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           mem [DEPTH];
  logic [AW-1:0]          wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   re_p_q, re_p_d;
  logic [N-1:0]           r_q, r_d, head_oh;
  logic [15:0]            tok_q, tok_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   errt_q, errt_d, errp_q, errp_d;
  logic                   push, pop, empty, re_s, wd_run;
  logic                   unused_pwr;

  assign unused_pwr    = VDD ^ GND;
  assign empty         = cnt_q == '0;
  assign bus.din_ready = !RESET && cnt_q != CW'(DEPTH);
  assign push          = bus.din_valid && bus.din_ready;
  assign re_s          = sync_q[SYNC_STAGES-1];
  assign bus.R         = r_q;
  assign busy          = !empty || state_q != IDLE;
  assign err_timeout   = errt_q;
  assign err_proto     = errp_q;
  assign tok_count     = tok_q;

  // one-hot rail pattern for the word at the FIFO head
  always_comb begin
    head_oh = '0;
    for (int i = 0; i < DIGITS; i++)
      for (int v = 0; v < RADIX; v++)
        head_oh[i*RADIX+v] = mem[rp_q][i*B +: B] == B'(v);
  end

  // handshake FSM, FIFO pointers, watchdog and sticky error flags
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    tok_d   = tok_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty && re_s) begin
        r_d     = head_oh;
        pop     = 1'b1;
        state_d = DATA;
      end
      DATA: if (!re_s) begin
        r_d     = '0;
        state_d = NEUTRAL;
      end
      NEUTRAL: if (re_s) begin
        tok_d   = tok_q + 16'd1;
        state_d = IDLE;
      end
      default: begin
        r_d     = '0;
        state_d = IDLE;
      end
    endcase
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.Re};
    re_p_d = re_s;
    wd_run = state_q != IDLE || (!empty && !re_s);
    wd_d   = (state_d != state_q || !wd_run) ? '0 : (wd_q == WD_MAX ? wd_q : wd_q + 1'b1);
    errt_d = errt_q || (TIMEOUT != 0 && wd_d == WD_MAX);
    errp_d = errp_q || (state_q == IDLE && re_p_q && !re_s)
                    || (state_q == DATA && re_p_q && !re_s && sync_q[SYNC_STAGES-2]);
  end

  // word storage; contents need no reset since the pointers gate validity
  always_ff @(posedge CLK) begin
    if (push) mem[wp_q] <= bus.din;
  end

  // state registers; reset drops the rails to neutral without waiting on Re
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      sync_q  <= '0;
      re_p_q  <= 1'b0;
      r_q     <= '0;
      tok_q   <= '0;
      wd_q    <= '0;
      errt_q  <= 1'b0;
      errp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      re_p_q  <= re_p_d;
      r_q     <= r_d;
      tok_q   <= tok_d;
      wd_q    <= wd_d;
      errt_q  <= errt_d;
      errp_q  <= errp_d;
    end
  end
endmodule

// File: tb/tb_bin2qdi_1ofn_src.sv
// tb_bin2qdi_1ofn_src: quad-rail and dual-rail sources driven in lockstep against a queue-based model
module tb_bin2qdi_1ofn_src;
  localparam int S = 2;
  localparam int T = 16;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  wire vdd = 1'b1;
  wire gnd = 1'b0;

  logic [7:0] din = '0;
  logic din_valid = 1'b0;
  logic Re = 1'b0;

  bin2qdi_1ofn_src_if #(.W(8), .N(16)) bus_a ();
  bin2qdi_1ofn_src_if #(.W(8), .N(16)) bus_b ();
  assign bus_a.din = din;
  assign bus_a.din_valid = din_valid;
  assign bus_a.Re = Re;
  assign bus_b.din = din;
  assign bus_b.din_valid = din_valid;
  assign bus_b.Re = Re;

  logic busy_a, et_a, ep_a, busy_b, et_b, ep_b;
  logic [15:0] tok_a, tok_b;

  bin2qdi_1ofn_src #(.RADIX(4), .DIGITS(4), .DEPTH(DEPTH), .SYNC_STAGES(S), .TIMEOUT(T)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a), .busy(busy_a), .err_timeout(et_a),
    .err_proto(ep_a), .tok_count(tok_a), .VDD(vdd), .GND(gnd));

  bin2qdi_1ofn_src #(.RADIX(2), .DIGITS(8), .DEPTH(DEPTH), .SYNC_STAGES(S), .TIMEOUT(T)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b), .busy(busy_b), .err_timeout(et_b),
    .err_proto(ep_b), .tok_count(tok_b), .VDD(vdd), .GND(gnd));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc(input logic [7:0] w, input int radix, input int digits);
    logic [15:0] r = '0;
    int b = radix == 2 ? 1 : (radix == 4 ? 2 : 3);
    for (int i = 0; i < digits; i++) r[i*radix + ((int'(w) >> (i*b)) % radix)] = 1'b1;
    return r;
  endfunction

  // reference: queue of words, token phase (0 waiting, 1 showing data, 2 returning), delayed Re
  logic [7:0] q[$];
  int phase = 0;
  logic [7:0] cur = '0;
  int wd = 0;
  bit m_to = 0, m_pe = 0;
  logic [15:0] m_tok = '0;
  logic [7:0] hist = '0;

  always @(posedge CLK or posedge RESET) begin
    bit rs, pv, nx, pend;
    int np, sz;
    if (RESET) begin
      q.delete();
      phase = 0; wd = 0; m_to = 0; m_pe = 0; m_tok = '0; hist = '0;
    end else begin
      rs = hist[S-1]; pv = hist[S]; nx = hist[S-2]; sz = q.size();
      if (phase == 0 && pv && !rs) m_pe = 1;
      if (phase == 1 && pv && !rs && nx) m_pe = 1;
      pend = phase != 0 || (sz != 0 && !rs);
      np = phase;
      if (phase == 0 && sz != 0 && rs) begin cur = q.pop_front(); np = 1; end
      else if (phase == 1 && !rs) np = 2;
      else if (phase == 2 && rs) begin np = 0; m_tok = m_tok + 16'd1; end
      wd = (np != phase || !pend) ? 0 : (wd < T ? wd + 1 : T);
      if (wd == T) m_to = 1;
      phase = np;
      if (din_valid && sz < DEPTH) q.push_back(din);
      hist = {hist[6:0], Re};
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("R_a", bus_a.R, phase == 1 ? enc(cur, 4, 4) : 16'h0);
    chk("R_b", bus_b.R, phase == 1 ? enc(cur, 2, 8) : 16'h0);
    chk("rdy_a", bus_a.din_ready, !RESET && q.size() < DEPTH);
    chk("rdy_b", bus_b.din_ready, !RESET && q.size() < DEPTH);
    chk("busy_a", busy_a, q.size() != 0 || phase != 0);
    chk("busy_b", busy_b, q.size() != 0 || phase != 0);
    chk("tok_a", tok_a, m_tok);
    chk("tok_b", tok_b, m_tok);
    chk("to_a", et_a, m_to);
    chk("to_b", et_b, m_to);
    chk("pe_a", ep_a, m_pe);
    chk("pe_b", ep_b, m_pe);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input logic [7:0] w);
    din = w; din_valid = 1'b1;
    @(negedge CLK);
    din_valid = 1'b0;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("rst_R", bus_a.R, 0);
    chk("rst_rdy", bus_a.din_ready, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_tok", tok_a, 0);
    chk("rst_err", {et_a, ep_a}, 0);
    RESET = 1'b0;
    // single token through a full handshake
    Re = 1'b1; cyc(3);
    push(8'hE4);
    chk("t1_pre", bus_a.R, 0);
    cyc(1); chk("t1_data", bus_a.R, 16'h8421);
    Re = 1'b0; cyc(2); chk("t1_hold", bus_a.R, 16'h8421);
    cyc(1); chk("t1_neut", bus_a.R, 0);
    Re = 1'b1; cyc(3); chk("t1_tok", tok_a, 1);
    // fill past full, then drain in order
    do_reset; Re = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din = 8'(i); din_valid = 1'b1;
      @(negedge CLK);
      if (i == 7) chk("t2_full", bus_a.din_ready, 0);
    end
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Re = 1'b1; cyc(5); chk("t2_word", bus_a.R, enc(8'(i), 4, 4));
      Re = 1'b0; cyc(5);
    end
    Re = 1'b1; cyc(5);
    chk("t2_tok", tok_a, 8);
    chk("t2_empty", busy_a, 0);
    // watchdog while the circuit never drops Re
    do_reset; Re = 1'b1; cyc(3);
    push(8'h5A);
    cyc(16); chk("t3_early", et_a, 0); chk("t3_R", bus_a.R, enc(8'h5A, 4, 4));
    cyc(1); chk("t3_to", et_a, 1); chk("t3_Rheld", bus_a.R, enc(8'h5A, 4, 4));
    Re = 1'b0; cyc(4); Re = 1'b1; cyc(4);
    chk("t3_tok", tok_a, 1); chk("t3_sticky", et_a, 1);
    // Re glitch while idle
    do_reset; Re = 1'b1; cyc(4);
    chk("t4_pre", ep_a, 0);
    Re = 1'b0; cyc(1); Re = 1'b1; cyc(4);
    chk("t4_pe", ep_a, 1); chk("t4_R", bus_a.R, 0); chk("t4_busy", busy_a, 0);
    // reset mid-token with words queued
    do_reset; Re = 1'b1; cyc(3);
    for (int i = 1; i <= 4; i++) begin
      din = 8'(i); din_valid = 1'b1;
      @(negedge CLK);
    end
    din_valid = 1'b0;
    chk("t5_data", bus_a.R, enc(8'h01, 4, 4)); chk("t5_busy", busy_a, 1);
    RESET = 1'b1; #1;
    chk("t5_R0", bus_a.R, 0); chk("t5_busy0", busy_a, 0); chk("t5_rdy0", bus_a.din_ready, 0);
    @(negedge CLK); RESET = 1'b0; cyc(3);
    push(8'h1B); cyc(1);
    chk("t5_1b", bus_a.R, 16'h1248);
    // dual-rail digit ordering
    do_reset; Re = 1'b1; cyc(3);
    push(8'hA5); cyc(1);
    chk("t6_dual", bus_b.R, 16'h9966);
    chk("t6_quad", bus_a.R, 16'h4422);
    // random traffic with occasional short Re pulses
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      din = 8'($urandom);
      din_valid = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 7) == 0) Re = ~Re;
      @(negedge CLK);
    end
    din_valid = 1'b0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
